// File: rtl/mipi_rx_pkg.sv
// Shared constants and helpers for the MIPI D-PHY receive lane.
package mipi_rx_pkg;

  localparam int TAP_W = 6;
  localparam logic [TAP_W-1:0] TAP_MAX = 6'd63;

  function automatic logic rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/mipi_rx_lane_if.sv
// Pad-side and deskew-side signal bundle of one MIPI receive lane.
interface mipi_rx_lane_if #(
  parameter int WIDTH = 4
);
  import mipi_rx_pkg::*;

  logic             PLL_LOCK;
  logic             CLK_IN;
  logic             RX_DP;
  logic             RX_DN;
  logic             HS_EN;
  logic             LP_EN;
  logic             RX_TERM_EN;
  logic             BITSLIP_ADJ;
  logic             DLY_LOAD;
  logic             DLY_ADJ;
  logic             DLY_INCDEC;
  logic [TAP_W-1:0] DLY_TAP_VALUE;
  logic [WIDTH-1:0] HS_RX_DATA;
  logic             HS_RXD_VALID;
  logic             RX_OE;
  logic             LP_RX_DP;
  logic             LP_RX_DN;

  // HS_RXD_VALID is a valid-only qualifier with no ready: a new word is offered
  // once per word boundary and the consumer must take it then.
  modport master (
    output PLL_LOCK, CLK_IN, RX_DP, RX_DN, HS_EN, LP_EN, RX_TERM_EN,
           BITSLIP_ADJ, DLY_LOAD, DLY_ADJ, DLY_INCDEC,
    input  DLY_TAP_VALUE, HS_RX_DATA, HS_RXD_VALID, RX_OE, LP_RX_DP, LP_RX_DN
  );

  modport slave (
    input  PLL_LOCK, CLK_IN, RX_DP, RX_DN, HS_EN, LP_EN, RX_TERM_EN,
           BITSLIP_ADJ, DLY_LOAD, DLY_ADJ, DLY_INCDEC,
    output DLY_TAP_VALUE, HS_RX_DATA, HS_RXD_VALID, RX_OE, LP_RX_DP, LP_RX_DN
  );

endinterface

// File: rtl/mipi_rx_dly_ctrl.sv
// Input-delay tap controller: reload from DELAY, saturating inc/dec steps.
// Only live when the top enables it and EN_IDLY is "TRUE"; otherwise the tap is 0.
module mipi_rx_dly_ctrl
  import mipi_rx_pkg::*;
#(
  parameter bit    CTRL_ON = 1'b0,
  parameter string EN_IDLY = "FALSE",
  parameter int    DELAY   = 0
) (
  input  logic             RX_CLK,
  input  logic             RST,
  input  logic             dly_load,
  input  logic             dly_adj,
  input  logic             dly_incdec,
  output logic [TAP_W-1:0] tap
);

  localparam bit ON = CTRL_ON && (EN_IDLY == "TRUE");
  localparam logic [TAP_W-1:0] RELOAD = TAP_W'(DELAY);

  generate
    if (ON) begin : g_on
      logic load_q;
      logic adj_q;

      // A reload wins over a step arriving in the same cycle.
      always_ff @(posedge RX_CLK or negedge RST) begin
        if (!RST) begin
          load_q <= 1'b0;
          adj_q  <= 1'b0;
          tap    <= RELOAD;
        end else begin
          load_q <= dly_load;
          adj_q  <= dly_adj;
          if (rise(dly_load, load_q)) begin
            tap <= RELOAD;
          end else if (rise(dly_adj, adj_q)) begin
            if (dly_incdec) begin
              if (tap != TAP_MAX) tap <= tap + TAP_W'(1);
            end else if (tap != '0) begin
              tap <= tap - TAP_W'(1);
            end
          end
        end
      end
    end else begin : g_off
      logic unused_cfg;
      assign unused_cfg = ^{RX_CLK, RST, dly_load, dly_adj, dly_incdec, RELOAD};
      assign tap = '0;
    end
  endgenerate

endmodule

// File: rtl/mipi_rx_lane.sv
// MIPI D-PHY receive lane front end: HS deserialiser with bitslip, LP pass-through.
// Define MIPI_RX_DLY_CTRL_EN to compile in the delay-tap controller.
module mipi_rx_lane
  import mipi_rx_pkg::*;
#(
  parameter int    WIDTH   = 4,
  parameter string EN_IDLY = "FALSE",
  parameter int    DELAY   = 0
) (
  input  logic          RX_CLK,
  input  logic          RST,
  mipi_rx_lane_if.slave lane
);

  localparam int SR_W   = 2 * WIDTH;
  localparam int SLIP_W = $clog2(WIDTH);
  localparam int FILL_W = $clog2(SR_W + 1);

`ifdef MIPI_RX_DLY_CTRL_EN
  localparam bit CTRL_ON = 1'b1;
`else
  localparam bit CTRL_ON = 1'b0;
`endif

  logic [SR_W-1:0]   sr;
  logic [SLIP_W-1:0] slip;
  logic [FILL_W-1:0] fill;
  logic              clk_in_q;
  logic              bitslip_q;
  logic              active;
  logic              boundary;
  logic              filled;
  logic              slip_rise;
  logic [WIDTH-1:0]  word;
  logic              unused_pad;

  // Termination is a pad-only control and the oldest history bit is never windowed.
  assign unused_pad = ^{lane.RX_TERM_EN, sr[SR_W-1]};

  always_comb begin
    active    = lane.HS_EN & lane.PLL_LOCK;
    boundary  = rise(lane.CLK_IN, clk_in_q);
    filled    = (fill == FILL_W'(SR_W));
    slip_rise = rise(lane.BITSLIP_ADJ, bitslip_q);
    word      = sr[slip +: WIDTH];
  end

  // Newest bit enters at sr[0], so the window's MSB is the earliest bit received.
  always_ff @(posedge RX_CLK or negedge RST) begin
    if (!RST) begin
      sr                <= '0;
      slip              <= '0;
      fill              <= '0;
      clk_in_q          <= 1'b0;
      bitslip_q         <= 1'b0;
      lane.HS_RX_DATA   <= '0;
      lane.HS_RXD_VALID <= 1'b0;
      lane.RX_OE        <= 1'b0;
      lane.LP_RX_DP     <= 1'b0;
      lane.LP_RX_DN     <= 1'b0;
    end else begin
      clk_in_q      <= lane.CLK_IN;
      bitslip_q     <= lane.BITSLIP_ADJ;
      lane.RX_OE    <= lane.HS_EN | lane.LP_EN;
      lane.LP_RX_DP <= lane.LP_EN & lane.RX_DP;
      lane.LP_RX_DN <= lane.LP_EN & lane.RX_DN;
      if (!active) begin
        sr                <= '0;
        slip              <= '0;
        fill              <= '0;
        lane.HS_RXD_VALID <= 1'b0;
      end else begin
        sr <= {sr[SR_W-2:0], lane.RX_DP};
        if (!filled) fill <= fill + FILL_W'(1);
        if (slip_rise) slip <= (slip == SLIP_W'(WIDTH - 1)) ? '0 : slip + SLIP_W'(1);
        // Words are only published once the history holds a full refill of bits.
        if (boundary) begin
          lane.HS_RXD_VALID <= filled;
          if (filled) lane.HS_RX_DATA <= word;
        end
      end
    end
  end

  mipi_rx_dly_ctrl #(
    .CTRL_ON (CTRL_ON),
    .EN_IDLY (EN_IDLY),
    .DELAY   (DELAY)
  ) u_dly_ctrl (
    .RX_CLK     (RX_CLK),
    .RST        (RST),
    .dly_load   (lane.DLY_LOAD),
    .dly_adj    (lane.DLY_ADJ),
    .dly_incdec (lane.DLY_INCDEC),
    .tap        (lane.DLY_TAP_VALUE)
  );

endmodule

// File: tb/tb_mipi_rx_lane.sv
// Directed bench for mipi_rx_lane: reset, HS alignment/bitslip, words, LP, relock, taps.
module tb_mipi_rx_lane;

  localparam int WIDTH = 4;
`ifdef MIPI_RX_DLY_CTRL_EN
  localparam bit TAP_ON = 1'b1;
`else
  localparam bit TAP_ON = 1'b0;
`endif

  logic RX_CLK = 1'b0;
  logic RST;

  mipi_rx_lane_if #(.WIDTH(WIDTH)) bus ();

  mipi_rx_lane #(
    .WIDTH   (WIDTH),
    .EN_IDLY ("TRUE"),
    .DELAY   (62)
  ) dut (
    .RX_CLK (RX_CLK),
    .RST    (RST),
    .lane   (bus)
  );

  always #5 RX_CLK = ~RX_CLK;

  int               errors    = 0;
  int               checks    = 0;
  int               cyc       = 0;
  int               bits_in   = 0;
  int               exp_slip  = 0;
  logic             exp_valid = 1'b0;
  logic [WIDTH-1:0] last_data = '0;
  logic [WIDTH-1:0] prev_word = '0;
  bit               word_mode = 1'b0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] words[3];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One RX_CLK cycle. CLK_IN runs 0,0,1,1 so every cycle with cyc%4==2 is a boundary.
  task automatic tick(input logic dp);
    logic bnd;
    logic act;
    bus.CLK_IN = cyc[1];
    bus.RX_DP  = dp;
    bnd = (cyc % 4 == 2);
    act = bus.HS_EN & bus.PLL_LOCK;
    if (act && bnd && bits_in >= 2 * WIDTH)
      exp_q.push_back(word_mode ? prev_word : ((exp_slip % 2 == 1) ? 4'h5 : 4'hA));
    @(posedge RX_CLK);
    #1;
    if (!act) begin
      bits_in   = 0;
      exp_slip  = 0;
      exp_valid = 1'b0;
    end else begin
      if (bnd) begin
        exp_valid = (bits_in >= 2 * WIDTH);
        if (exp_valid) last_data = exp_q.pop_front();
      end
      bits_in++;
    end
    chk1("hs_valid", bus.HS_RXD_VALID, exp_valid);
    chk8("hs_data", 8'(bus.HS_RX_DATA), 8'(last_data));
    chk1("lp_dp", bus.LP_RX_DP, bus.LP_EN & dp);
    chk1("lp_dn", bus.LP_RX_DN, bus.LP_EN & bus.RX_DN);
    chk1("rx_oe", bus.RX_OE, bus.HS_EN | bus.LP_EN);
    cyc++;
  endtask

  task automatic run_alt(input int n);
    for (int i = 0; i < n; i++) tick(cyc % 2 == 0);
  endtask

  task automatic align(input int phase);
    while (cyc % 4 != phase) tick(cyc % 2 == 0);
  endtask

  // Rising edge at a phase-0 cycle, held for two CLK_IN periods.
  task automatic slip_pulse();
    align(0);
    exp_slip = (exp_slip + 1) % WIDTH;
    bus.BITSLIP_ADJ = 1'b1;
    run_alt(8);
    bus.BITSLIP_ADJ = 1'b0;
    run_alt(8);
  endtask

  task automatic adj_pulse(input logic inc);
    bus.DLY_INCDEC = inc;
    bus.DLY_ADJ    = 1'b1;
    tick(1'b0);
    bus.DLY_ADJ    = 1'b0;
    tick(1'b0);
  endtask

  task automatic load_pulse(input logic with_adj);
    bus.DLY_LOAD = 1'b1;
    bus.DLY_ADJ  = with_adj;
    tick(1'b0);
    bus.DLY_LOAD = 1'b0;
    bus.DLY_ADJ  = 1'b0;
    tick(1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    words[0] = 4'hA;
    words[1] = 4'hC;
    words[2] = 4'hD;
    RST             = 1'b0;
    bus.PLL_LOCK    = 1'b0;
    bus.CLK_IN      = 1'b0;
    bus.RX_DP       = 1'b0;
    bus.RX_DN       = 1'b0;
    bus.HS_EN       = 1'b0;
    bus.LP_EN       = 1'b0;
    bus.RX_TERM_EN  = 1'b0;
    bus.BITSLIP_ADJ = 1'b0;
    bus.DLY_LOAD    = 1'b0;
    bus.DLY_ADJ     = 1'b0;
    bus.DLY_INCDEC  = 1'b0;

    // Reset held for two cycles
    repeat (2) @(posedge RX_CLK);
    #1;
    chk8("rst_data", 8'(bus.HS_RX_DATA), 8'h00);
    chk1("rst_valid", bus.HS_RXD_VALID, 1'b0);
    chk1("rst_rx_oe", bus.RX_OE, 1'b0);
    chk1("rst_lp_dp", bus.LP_RX_DP, 1'b0);
    chk1("rst_lp_dn", bus.LP_RX_DN, 1'b0);
    chk8("rst_tap", 8'(bus.DLY_TAP_VALUE), TAP_ON ? 8'd62 : 8'd0);
    RST = 1'b1;

    // Alternating HS pattern; valid appears once 8 bits have been captured
    bus.PLL_LOCK   = 1'b1;
    bus.HS_EN      = 1'b1;
    bus.RX_TERM_EN = 1'b1;
    run_alt(12);
    chk1("fill_valid", bus.HS_RXD_VALID, 1'b1);
    chk8("fill_data", 8'(bus.HS_RX_DATA), 8'h0A);

    // Three slips land on an odd offset, a fourth brings the window back to 0
    slip_pulse();
    slip_pulse();
    slip_pulse();
    chk8("slip3_data", 8'(bus.HS_RX_DATA), 8'h05);
    slip_pulse();
    chk8("slip4_data", 8'(bus.HS_RX_DATA), 8'h0A);

    // Words sent MSB first starting on a boundary cycle
    align(2);
    for (int k = 0; k < 3; k++) begin
      for (int i = WIDTH - 1; i >= 0; i--) tick(words[k][i]);
      prev_word = words[k];
      word_mode = 1'b1;
    end
    tick(1'b0);
    word_mode = 1'b0;
    chk8("word_d", 8'(bus.HS_RX_DATA), 8'h0D);

    // LP pass-through with HS off
    bus.HS_EN = 1'b0;
    bus.LP_EN = 1'b1;
    bus.RX_DN = 1'b0;
    tick(1'b1);
    tick(1'b1);
    chk1("lp5_dp", bus.LP_RX_DP, 1'b1);
    chk1("lp5_dn", bus.LP_RX_DN, 1'b0);
    chk1("lp5_oe", bus.RX_OE, 1'b1);
    chk1("lp5_valid", bus.HS_RXD_VALID, 1'b0);
    chk8("lp5_hold", 8'(bus.HS_RX_DATA), 8'h0D);
    bus.RX_DN = 1'b1;
    tick(1'b0);
    bus.LP_EN = 1'b0;
    tick(1'b0);
    chk1("idle_oe", bus.RX_OE, 1'b0);

    // HS and LP together, then a lock drop with a pending slip must clear it
    bus.HS_EN = 1'b1;
    bus.LP_EN = 1'b1;
    run_alt(16);
    slip_pulse();
    chk8("relock_pre", 8'(bus.HS_RX_DATA), 8'h05);
    bus.PLL_LOCK = 1'b0;
    run_alt(4);
    chk1("unlock_valid", bus.HS_RXD_VALID, 1'b0);
    bus.PLL_LOCK = 1'b1;
    run_alt(16);
    chk8("relock_data", 8'(bus.HS_RX_DATA), 8'h0A);
    chk1("relock_valid", bus.HS_RXD_VALID, 1'b1);

    // Delay taps
    bus.HS_EN = 1'b0;
    bus.LP_EN = 1'b0;
    adj_pulse(1'b1);
    chk8("tap_inc1", 8'(bus.DLY_TAP_VALUE), TAP_ON ? 8'd63 : 8'd0);
    adj_pulse(1'b1);
    chk8("tap_sat_hi", 8'(bus.DLY_TAP_VALUE), TAP_ON ? 8'd63 : 8'd0);
    load_pulse(1'b0);
    chk8("tap_load", 8'(bus.DLY_TAP_VALUE), TAP_ON ? 8'd62 : 8'd0);
    for (int i = 0; i < 31; i++) adj_pulse(1'b0);
    chk8("tap_dec31", 8'(bus.DLY_TAP_VALUE), TAP_ON ? 8'd31 : 8'd0);
    for (int i = 0; i < 32; i++) adj_pulse(1'b0);
    chk8("tap_sat_lo", 8'(bus.DLY_TAP_VALUE), 8'd0);
    load_pulse(1'b1);
    chk8("tap_load_prio", 8'(bus.DLY_TAP_VALUE), TAP_ON ? 8'd62 : 8'd0);
    adj_pulse(1'b0);
    chk8("tap_dec1", 8'(bus.DLY_TAP_VALUE), TAP_ON ? 8'd61 : 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
